// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - controller/debug strobes and status bundle for pc_sequencer
interface pc_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int IRQ_N  = 4
);
    localparam int ID_W = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;

    logic              fetch;
    logic              ex_jump;
    logic              ex_call;
    logic              ex_ret_sub;
    logic              ex_ret_int;
    logic [ADDR_W-1:0] jump_addr;
    logic [IRQ_N-1:0]  irq;
    logic [IRQ_N-1:0]  irq_mask;
    logic              flag_ie;
    logic              int_enter;
    logic              dbg_is_brk;
    logic              dbg_pc_wr;
    logic [ADDR_W-1:0] dbg_data_in;
    logic [ADDR_W-1:0] pc;
    logic              int_req;
    logic [ID_W-1:0]   int_id;
    logic              int_active;
    logic              stack_full;
    logic              stack_empty;
    logic [1:0]        stack_err;

    modport master (
        output fetch, ex_jump, ex_call, ex_ret_sub, ex_ret_int, jump_addr,
               irq, irq_mask, flag_ie, int_enter, dbg_is_brk, dbg_pc_wr, dbg_data_in,
        input  pc, int_req, int_id, int_active, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  fetch, ex_jump, ex_call, ex_ret_sub, ex_ret_int, jump_addr,
               irq, irq_mask, flag_ie, int_enter, dbg_is_brk, dbg_pc_wr, dbg_data_in,
        output pc, int_req, int_id, int_active, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter, return stack and vectored interrupt front-end
// Optional build macro NESTED_INT_EN: lets a higher-priority channel preempt a running ISR.
module pc_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 8,
    parameter int IRQ_N       = 4,
    parameter int RST_VECTOR  = 0,
    parameter int INT_BASE    = 'h10,
    parameter int VEC_STRIDE  = 4
) (
    input logic            clk,
    input logic            rst,
    pc_sequencer_if.slave  bus
);
    localparam int ID_W  = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;
    localparam int LVL_W = $clog2(IRQ_N + 1);
    localparam int ENT_W = ADDR_W + LVL_W + 1;
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = $clog2(STACK_DEPTH);

    localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RST_VECTOR);
    localparam logic [LVL_W-1:0]  LVL_IDLE = LVL_W'(IRQ_N);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] pc_q;
    logic              int_active_q;
    logic [LVL_W-1:0]  active_level;
    logic [CNT_W-1:0]  count;
    logic [1:0]        stack_err_q;
    logic [ENT_W-1:0]  stack_mem [STACK_DEPTH];

    logic [IRQ_N-1:0]  pending;
    logic [ID_W-1:0]   int_id;
    logic              int_req;
    logic [ADDR_W-1:0] vec_addr;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  top_idx;
    logic [ENT_W-1:0]  top_entry;
    logic [ENT_W-1:0]  sub_entry;
    logic [ENT_W-1:0]  irq_entry;

    assign pending = bus.irq & bus.irq_mask;

    // Scan downward so the lowest pending index wins.
    always_comb begin
        int_id = '0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (pending[i]) int_id = ID_W'(i);
        end
    end

`ifdef NESTED_INT_EN
    assign int_req = bus.flag_ie & (|pending) &
                     (~int_active_q | (LVL_W'(int_id) < active_level));
`else
    assign int_req = bus.flag_ie & (|pending) & ~int_active_q;
`endif

    assign vec_addr  = ADDR_W'(INT_BASE + int'(int_id) * VEC_STRIDE);
    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign top_idx   = count - CNT_W'(1);
    assign top_entry = stack_mem[top_idx[PTR_W-1:0]];
    assign sub_entry = {1'b0, active_level, pc_q};
    assign irq_entry = {int_active_q, active_level, pc_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RST_PC;
            int_active_q <= 1'b0;
            active_level <= LVL_IDLE;
            count        <= '0;
            stack_err_q  <= 2'b00;
        end else if (bus.dbg_is_brk) begin
            // Halted: only the debugger may move pc; stack and ISR state frozen.
            if (bus.dbg_pc_wr) pc_q <= bus.dbg_data_in;
        end else if (bus.int_enter && int_req) begin
            pc_q         <= vec_addr;
            int_active_q <= 1'b1;
            active_level <= LVL_W'(int_id);
            if (full) begin
                stack_err_q[0] <= 1'b1;
            end else begin
                stack_mem[count[PTR_W-1:0]] <= irq_entry;
                count                       <= count + CNT_W'(1);
            end
        end else if (bus.ex_jump || bus.ex_call) begin
            pc_q <= bus.jump_addr;
            if (bus.ex_call) begin
                if (full) begin
                    stack_err_q[0] <= 1'b1;
                end else begin
                    stack_mem[count[PTR_W-1:0]] <= sub_entry;
                    count                       <= count + CNT_W'(1);
                end
            end
        end else if (bus.ex_ret_sub || bus.ex_ret_int) begin
            if (empty) begin
                pc_q           <= RST_PC;
                int_active_q   <= 1'b0;
                stack_err_q[1] <= 1'b1;
            end else begin
                pc_q  <= top_entry[ADDR_W-1:0];
                count <= top_idx;
                if (bus.ex_ret_int) begin
                    int_active_q <= top_entry[ENT_W-1];
                    active_level <= top_entry[ADDR_W +: LVL_W];
                end
            end
        end else if (bus.fetch) begin
            pc_q <= pc_q + ADDR_W'(1);
        end
    end

    assign bus.pc          = pc_q;
    assign bus.int_req     = int_req;
    assign bus.int_id      = int_id;
    assign bus.int_active  = int_active_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stack_err   = stack_err_q;
endmodule
